// File: rtl/writeback_stage_pkg.sv
// Shared pipeline encodings for the writeback stage and its load extender.
package writeback_stage_pkg;

    // Load type encodings; must match the control decoder.
    localparam logic [2:0] LD_WORD = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;

    // Select-data-to-reg encodings; must match the control decoder.
    localparam logic [1:0] SD_ALU = 2'd0;
    localparam logic [1:0] SD_MEM = 2'd1;
    localparam logic [1:0] SD_PC8 = 2'd2;

    // Contents of the W pipeline register.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu_out;
        logic [31:0] read_data;
        logic [1:0]  addr_lo;
        logic [2:0]  ld_type;
        logic [1:0]  sd_to_reg;
        logic        reg_write;
        logic [4:0]  write_reg;
    } w_reg_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Sub-word load extraction from a little-endian aligned 32-bit word.
module load_extend
    import writeback_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half, then sign- or zero-extend per load type.
    always_comb begin
        byte_sel = din[7:0];
        case (addr_lo)
            2'd0: byte_sel = din[7:0];
            2'd1: byte_sel = din[15:8];
            2'd2: byte_sel = din[23:16];
            2'd3: byte_sel = din[31:24];
            default: byte_sel = din[7:0];
        endcase

        // Halfword offset ignores addr_lo[0].
        half_sel = addr_lo[1] ? din[31:16] : din[15:0];

        dout = din;
        case (ld_type)
            LD_WORD: dout = din;
            LD_LB:   dout = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  dout = {24'h000000, byte_sel};
            LD_LH:   dout = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  dout = {16'h0000, half_sel};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// W stage: pipeline register, writeback result select, GRF write port and
// retired-instruction counter. All outputs depend only on W register state.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_w,
    input  logic                flush_w,
    input  logic                valid_m,
    input  logic [31:0]         pc_m,
    input  logic [31:0]         instr_m,
    input  logic [31:0]         alu_out_m,
    input  logic [31:0]         read_data_m,
    input  logic [2:0]          ld_type_m,
    input  logic [1:0]          sd_to_reg_m,
    input  logic                reg_write_m,
    input  logic [4:0]          write_reg_m,
    output logic                grf_we,
    output logic [4:0]          grf_a3,
    output logic [31:0]         grf_wd,
    output logic [31:0]         grf_pc,
    output logic [31:0]         pc_w,
    output logic [31:0]         instr_w,
    output logic [RETIRE_W-1:0] retire_cnt
);

    w_reg_t              w_q, w_d;
    logic [RETIRE_W-1:0] cnt_q, cnt_d;
    logic [31:0]         ld_data;

    // Next-state: flush beats stall; counter only advances on a real capture.
    always_comb begin
        w_d   = w_q;
        cnt_d = cnt_q;
        if (flush_w) begin
            w_d = '0;
        end else if (!stall_w) begin
            w_d.valid     = valid_m;
            w_d.pc        = pc_m;
            w_d.instr     = instr_m;
            w_d.alu_out   = alu_out_m;
            w_d.read_data = read_data_m;
            w_d.addr_lo   = alu_out_m[1:0];
            w_d.ld_type   = ld_type_m;
            w_d.sd_to_reg = sd_to_reg_m;
            w_d.reg_write = reg_write_m;
            w_d.write_reg = write_reg_m;
            if (valid_m) begin
                cnt_d = cnt_q + RETIRE_W'(1);
            end
        end
    end

    // W register and retire counter with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    load_extend u_load_extend (
        .ld_type (w_q.ld_type),
        .addr_lo (w_q.addr_lo),
        .din     (w_q.read_data),
        .dout    (ld_data)
    );

    // Writeback result select; encoding 3 falls back to the ALU result.
    always_comb begin
        grf_wd = w_q.alu_out;
        case (w_q.sd_to_reg)
            SD_ALU:  grf_wd = w_q.alu_out;
            SD_MEM:  grf_wd = ld_data;
            SD_PC8:  grf_wd = w_q.pc + 32'd8;
            default: grf_wd = w_q.alu_out;
        endcase
    end

    assign grf_we     = w_q.valid & w_q.reg_write & (|w_q.write_reg);
    assign grf_a3     = w_q.write_reg;
    assign grf_pc     = w_q.pc;
    assign pc_w       = w_q.pc;
    assign instr_w    = w_q.instr;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage, including a 4-bit
// retire counter instance to exercise wraparound.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_w, flush_w, valid_m;
    logic [31:0] pc_m, instr_m, alu_out_m, read_data_m;
    logic [2:0]  ld_type_m;
    logic [1:0]  sd_to_reg_m;
    logic        reg_write_m;
    logic [4:0]  write_reg_m;

    logic        grf_we, grf_we4;
    logic [4:0]  grf_a3, grf_a34;
    logic [31:0] grf_wd, grf_pc, pc_w, instr_w;
    logic [31:0] grf_wd4, grf_pc4, pc_w4, instr_w4;
    logic [31:0] retire_cnt;
    logic [3:0]  retire_cnt4;

    int vecs  = 0;
    int fails = 0;

    logic [31:0] lb_exp [4];

    always #5 clk = ~clk;

    writeback_stage #(.RETIRE_W(32)) dut (
        .clk(clk), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .pc_m(pc_m), .instr_m(instr_m), .alu_out_m(alu_out_m),
        .read_data_m(read_data_m), .ld_type_m(ld_type_m), .sd_to_reg_m(sd_to_reg_m),
        .reg_write_m(reg_write_m), .write_reg_m(write_reg_m),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .pc_w(pc_w), .instr_w(instr_w), .retire_cnt(retire_cnt)
    );

    writeback_stage #(.RETIRE_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .pc_m(pc_m), .instr_m(instr_m), .alu_out_m(alu_out_m),
        .read_data_m(read_data_m), .ld_type_m(ld_type_m), .sd_to_reg_m(sd_to_reg_m),
        .reg_write_m(reg_write_m), .write_reg_m(write_reg_m),
        .grf_we(grf_we4), .grf_a3(grf_a34), .grf_wd(grf_wd4), .grf_pc(grf_pc4),
        .pc_w(pc_w4), .instr_w(instr_w4), .retire_cnt(retire_cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        lb_exp[0] = 32'h00000001;
        lb_exp[1] = 32'h0000007F;
        lb_exp[2] = 32'hFFFFFFFF;
        lb_exp[3] = 32'hFFFFFF80;

        // Reset held low for two cycles with random M inputs.
        reset = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
        valid_m = 1'b1; pc_m = $urandom; instr_m = $urandom; alu_out_m = $urandom;
        read_data_m = $urandom; ld_type_m = 3'($urandom); sd_to_reg_m = 2'($urandom);
        reg_write_m = 1'b1; write_reg_m = 5'($urandom_range(1, 31));
        tick();
        pc_m = $urandom; alu_out_m = $urandom;
        tick();
        check("rst_we",   {31'd0, grf_we}, 32'd0);
        check("rst_a3",   {27'd0, grf_a3}, 32'd0);
        check("rst_wd",   grf_wd,  32'd0);
        check("rst_pc",   grf_pc,  32'd0);
        check("rst_pcw",  pc_w,    32'd0);
        check("rst_inw",  instr_w, 32'd0);
        check("rst_cnt",  retire_cnt, 32'd0);

        // First ALU writeback after reset release.
        reset = 1'b1;
        valid_m = 1'b1; reg_write_m = 1'b1; write_reg_m = 5'd8; sd_to_reg_m = 2'd0;
        alu_out_m = 32'h00001234; pc_m = 32'h00003000; instr_m = 32'h20081234;
        ld_type_m = 3'd0; read_data_m = 32'hDEADBEEF;
        tick();
        check("alu_we",  {31'd0, grf_we}, 32'd1);
        check("alu_a3",  {27'd0, grf_a3}, 32'd8);
        check("alu_wd",  grf_wd, 32'h00001234);
        check("alu_cnt", retire_cnt, 32'd1);
        check("alu_inw", instr_w, 32'h20081234);

        // Sub-word loads from 0x80FF7F01.
        read_data_m = 32'h80FF7F01; sd_to_reg_m = 2'd1; ld_type_m = 3'd1;
        for (int k = 0; k < 4; k++) begin
            alu_out_m = 32'h00001000 + k;
            tick();
            check($sformatf("lb_off%0d", k), grf_wd, lb_exp[k]);
        end
        check("lb_cnt", retire_cnt, 32'd5);
        ld_type_m = 3'd2; alu_out_m = 32'h00001003;
        tick();
        check("lbu_off3", grf_wd, 32'h00000080);
        ld_type_m = 3'd3; alu_out_m = 32'h00001002;
        tick();
        check("lh_off2", grf_wd, 32'hFFFF80FF);
        ld_type_m = 3'd4; alu_out_m = 32'h00001000;
        tick();
        check("lhu_off0", grf_wd, 32'h00007F01);
        ld_type_m = 3'd3; alu_out_m = 32'h00001003;
        tick();
        check("lh_off3", grf_wd, 32'hFFFF80FF);
        ld_type_m = 3'd5; alu_out_m = 32'h00001001;
        tick();
        check("ld5_word", grf_wd, 32'h80FF7F01);
        check("ld_cnt", retire_cnt, 32'd10);

        // jal link value PC+8, including wraparound.
        sd_to_reg_m = 2'd2; write_reg_m = 5'd31; pc_m = 32'h00003000; alu_out_m = 32'h0000BEEF;
        tick();
        check("jal_wd", grf_wd, 32'h00003008);
        check("jal_a3", {27'd0, grf_a3}, 32'd31);
        check("jal_pc", grf_pc, 32'h00003000);
        pc_m = 32'hFFFFFFFC;
        tick();
        check("jal_wrap", grf_wd, 32'h00000004);

        // sd_to_reg 3 falls back to ALU.
        sd_to_reg_m = 2'd3; alu_out_m = 32'h0000CAFE;
        tick();
        check("sd3_alu", grf_wd, 32'h0000CAFE);

        // Write to $0 is suppressed but still retires.
        sd_to_reg_m = 2'd0; write_reg_m = 5'd0; alu_out_m = 32'h00000055;
        tick();
        check("r0_we",  {31'd0, grf_we}, 32'd0);
        check("r0_wd",  grf_wd, 32'h00000055);
        check("r0_cnt", retire_cnt, 32'd14);

        // Load a known instruction, then stall for three cycles.
        write_reg_m = 5'd5; alu_out_m = 32'h0000AAAA; pc_m = 32'h00004000;
        instr_m = 32'h20050005;
        tick();
        check("pre_stall_cnt", retire_cnt, 32'd15);
        stall_w = 1'b1;
        for (int k = 0; k < 3; k++) begin
            write_reg_m = 5'd9 + 5'(k); alu_out_m = 32'h0000BBBB + k; pc_m = 32'h00005000 + 4*k;
            instr_m = 32'h11111111 * (k + 1);
            tick();
            check($sformatf("stall%0d_we", k),  {31'd0, grf_we}, 32'd1);
            check($sformatf("stall%0d_wd", k),  grf_wd, 32'h0000AAAA);
            check($sformatf("stall%0d_a3", k),  {27'd0, grf_a3}, 32'd5);
            check($sformatf("stall%0d_pcw", k), pc_w, 32'h00004000);
            check($sformatf("stall%0d_cnt", k), retire_cnt, 32'd15);
        end

        // Flush together with stall: bubble wins.
        flush_w = 1'b1;
        tick();
        check("flush_we",  {31'd0, grf_we}, 32'd0);
        check("flush_pcw", pc_w, 32'd0);
        check("flush_wd",  grf_wd, 32'd0);
        check("flush_inw", instr_w, 32'd0);
        check("flush_cnt", retire_cnt, 32'd15);

        // Bubble from M: captured but not retired, no write.
        flush_w = 1'b0; stall_w = 1'b0; valid_m = 1'b0; write_reg_m = 5'd3;
        pc_m = 32'h00006000;
        tick();
        check("bub_we",  {31'd0, grf_we}, 32'd0);
        check("bub_pcw", pc_w, 32'h00006000);
        check("bub_cnt", retire_cnt, 32'd15);

        // Reset beats stall.
        valid_m = 1'b1; reset = 1'b0; stall_w = 1'b1;
        tick();
        check("rststall_cnt", retire_cnt, 32'd0);
        check("rststall_pcw", pc_w, 32'd0);

        // 4-bit counter wraps after 16 retires; bubbles do not count.
        reset = 1'b1; stall_w = 1'b0; valid_m = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        check("wrap_pre4", {28'd0, retire_cnt4}, 32'd15);
        tick();
        check("wrap_4",  {28'd0, retire_cnt4}, 32'd0);
        check("wrap_32", retire_cnt, 32'd16);
        valid_m = 1'b0;
        tick();
        tick();
        check("wrap_bub4",  {28'd0, retire_cnt4}, 32'd0);
        check("wrap_bub32", retire_cnt, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
